// File: rtl/spi_peripheral.sv
// SPI target endpoint: oversamples SCLK/CS_N/COPI on i_clk, supports modes 0-3, TX via ready/valid holding register.
// Optional macro SPI_PERIPHERAL_ERR_EN adds o_underrun/o_abort status pulses.
module spi_peripheral #(
  parameter logic [1:0] DEFAULT_MODE  = 2'd0,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_config,
  input  logic [7:0] i_tx,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx,
  output logic       o_rx_valid,
  output logic       o_busy,
`ifdef SPI_PERIPHERAL_ERR_EN
  output logic       o_underrun,
  output logic       o_abort,
`endif
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_copi,
  output logic       o_cipo,
  output logic       o_cipo_oe
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, copi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_s, cs_s, copi_s;
  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, cs_fall, cs_rise;
  logic [1:0] mode;
  logic       cpol, cpha;
  logic [7:0] hold, tx_shift, load_byte;
  logic       hold_full, accept;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       cipo_q;
  logic       do_load, do_sample, do_shift;

  // CS_N chain resets to "selected" so a CS held low across reset never fakes a falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      copi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], i_copi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign copi_s      = copi_sync[SYNC_STAGES-1];
  assign cpol        = mode[1];
  assign cpha        = mode[0];
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s & cs_d;
  assign cs_rise     = cs_s & ~cs_d;

  assign o_tx_ready = ~hold_full;
  assign accept     = i_tx_valid & ~hold_full;
  assign load_byte  = hold_full ? hold : UNDERRUN_BYTE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // CPHA=0 loads the next byte on the shift edge that follows a completed byte; CPHA=1 right after the 8th sample.
  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    case (state)
      IDLE:  if (cs_fall) next_state = LOAD;
      LOAD: begin
        do_load    = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        if (sample_edge) begin
          do_sample = 1'b1;
          if (cpha && bit_cnt == 3'd7) next_state = LOAD;
        end else if (shift_edge) begin
          if (!cpha && bit_cnt == 3'd0) next_state = LOAD;
          else                          do_shift   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (cs_rise) begin
      next_state = IDLE;
      do_load    = 1'b0;
      do_sample  = 1'b0;
      do_shift   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode       <= DEFAULT_MODE;
      hold       <= 8'h00;
      hold_full  <= 1'b0;
      tx_shift   <= 8'h00;
      rx_shift   <= 7'h00;
      bit_cnt    <= 3'd0;
      cipo_q     <= 1'b0;
      o_rx       <= 8'h00;
      o_rx_valid <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      if (cs_s && i_config[0]) mode <= i_config[2:1];
      if (accept) begin
        hold      <= i_tx;
        hold_full <= 1'b1;
      end else if (do_load) begin
        hold_full <= 1'b0;
      end
      if (do_load) begin
        tx_shift <= load_byte;
        if (!cpha) cipo_q <= load_byte[7];
      end
      if (do_shift) begin
        cipo_q   <= cpha ? tx_shift[7] : tx_shift[6];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
      if (do_sample) begin
        rx_shift <= {rx_shift[5:0], copi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          o_rx       <= {rx_shift, copi_s};
          o_rx_valid <= 1'b1;
        end
      end
      if (cs_rise) begin
        bit_cnt <= 3'd0;
        cipo_q  <= 1'b0;
      end
    end
  end

`ifdef SPI_PERIPHERAL_ERR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_underrun <= 1'b0;
      o_abort    <= 1'b0;
    end else begin
      o_underrun <= do_load & ~hold_full;
      o_abort    <= cs_rise & (bit_cnt != 3'd0);
    end
  end
`endif

  // Busy follows the FSM so that a window interrupted by reset stays deselected.
  assign o_busy    = (state != IDLE);
  assign o_cipo_oe = o_busy;
  assign o_cipo    = o_busy & cipo_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: acts as SPI controller, table vectors + random windows + corner sequences.
module tb_spi_peripheral;
  localparam int HP = 4;

  logic       i_clk, i_rst_n;
  logic [2:0] i_config;
  logic [7:0] i_tx;
  logic       i_tx_valid, o_tx_ready;
  logic [7:0] o_rx;
  logic       o_rx_valid, o_busy;
  logic       i_sclk, i_cs_n, i_copi, o_cipo, o_cipo_oe;

  int vectors = 0;
  int miscompares = 0;
  logic cpol, cpha;
  logic [7:0] rx_log[$];
  logic [7:0] tx_model[$];
  int underrun_cnt = 0;
  int abort_cnt = 0;

`ifdef SPI_PERIPHERAL_ERR_EN
  logic o_underrun, o_abort;
  always @(negedge i_clk) begin
    if (o_underrun) underrun_cnt++;
    if (o_abort) abort_cnt++;
  end
`endif

  spi_peripheral dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_config(i_config),
    .i_tx(i_tx), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_rx(o_rx), .o_rx_valid(o_rx_valid), .o_busy(o_busy),
`ifdef SPI_PERIPHERAL_ERR_EN
    .o_underrun(o_underrun), .o_abort(o_abort),
`endif
    .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_copi(i_copi),
    .o_cipo(o_cipo), .o_cipo_oe(o_cipo_oe)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_rx_valid) rx_log.push_back(o_rx);

  typedef struct {
    logic [1:0] mode;
    logic [7:0] mo;
    logic       q;
    logic [7:0] txb;
    logic [7:0] exp_rx;
    logic [7:0] exp_mi;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tx_ready"}, 32'(o_tx_ready), 1);
    check({tag, "_rx"}, 32'(o_rx), 0);
    check({tag, "_rx_valid"}, 32'(o_rx_valid), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_cipo"}, 32'(o_cipo), 0);
    check({tag, "_cipo_oe"}, 32'(o_cipo_oe), 0);
  endtask

  task automatic apply_mode(input logic [1:0] m);
    i_config = {m, 1'b1};
    tick(1);
    i_config = 3'b000;
    cpol = m[1];
    cpha = m[0];
    i_sclk = m[1];
    tick(6);
  endtask

  task automatic queue_tx(input logic [7:0] b);
    int n;
    n = 0;
    i_tx = b;
    i_tx_valid = 1'b1;
    while (!o_tx_ready && n < 50) begin
      tick(1);
      n++;
    end
    check("tx_ready_wait", 32'(n < 50), 1);
    tick(1);
    i_tx_valid = 1'b0;
    check("tx_ready_drop", 32'(o_tx_ready), 0);
  endtask

  // Controller side: drives COPI/SCLK for nbits MSB-first and samples CIPO on the sample edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      if (!cpha) begin
        i_copi = mo[7-k];
        tick(HP);
        mi[7-k] = o_cipo;
        i_sclk = ~cpol;
        tick(HP);
        i_sclk = cpol;
      end else begin
        tick(HP);
        i_sclk = ~cpol;
        i_copi = mo[7-k];
        tick(HP);
        mi[7-k] = o_cipo;
        i_sclk = cpol;
      end
    end
  endtask

  task automatic run_window(input logic [7:0] mo, input logic q, input logic [7:0] txb,
                            output logic [7:0] mi);
    if (q) queue_tx(txb);
    rx_log.delete();
    i_cs_n = 1'b0;
    tick(8);
    xfer(mo, 8, mi);
    tick(HP);
    i_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic check_rx1(input string tag, input logic [7:0] exp);
    check({tag, "_rx_count"}, 32'(rx_log.size()), 1);
    if (rx_log.size() > 0) check({tag, "_rx"}, 32'(rx_log[0]), 32'(exp));
  endtask

  vec_t tbl[7];
  logic [7:0] mi, m1, m2, mo, txb, exp_mi;
  logic q;
  int u0, a0;

  initial begin
    tbl[0] = '{2'd0, 8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C};
    tbl[1] = '{2'd0, 8'h55, 1'b0, 8'h00, 8'h55, 8'hFF};
    tbl[2] = '{2'd1, 8'h0F, 1'b1, 8'hC3, 8'h0F, 8'hC3};
    tbl[3] = '{2'd2, 8'h80, 1'b1, 8'h01, 8'h80, 8'h01};
    tbl[4] = '{2'd3, 8'hFE, 1'b1, 8'h7F, 8'hFE, 8'h7F};
    tbl[5] = '{2'd3, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF};
    tbl[6] = '{2'd1, 8'h55, 1'b0, 8'h00, 8'h55, 8'hFF};

    i_rst_n = 1'b0; i_config = 3'b000; i_tx = 8'h00; i_tx_valid = 1'b0;
    i_sclk = 1'b0; i_cs_n = 1'b1; i_copi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tick(3);
    reset_checks("reset");
    i_rst_n = 1'b1;
    tick(6);
    reset_checks("post_reset");

    for (int i = 0; i < 7; i++) begin
      apply_mode(tbl[i].mode);
      u0 = underrun_cnt;
      run_window(tbl[i].mo, tbl[i].q, tbl[i].txb, mi);
      check_rx1("tbl", tbl[i].exp_rx);
      check("tbl_cipo", 32'(mi), 32'(tbl[i].exp_mi));
`ifdef SPI_PERIPHERAL_ERR_EN
      if (!tbl[i].q) check("tbl_underrun", 32'(underrun_cnt > u0), 1);
`endif
    end

    // Reference model: controller must see each queued byte in order, or the underrun byte.
    for (int m = 1; m <= 3; m++) begin
      apply_mode(2'(m));
      for (int n = 0; n < 255; n++) begin
        mo = 8'($urandom);
        txb = 8'($urandom);
        q = ($urandom_range(0, 3) != 0);
        if (q) tx_model.push_back(txb);
        exp_mi = (tx_model.size() > 0) ? tx_model.pop_front() : 8'hFF;
        run_window(mo, q, txb, mi);
        check_rx1("rand", mo);
        check("rand_cipo", 32'(mi), 32'(exp_mi));
      end
    end

    // Mode 3: two bytes back to back in one window.
    apply_mode(2'd3);
    rx_log.delete();
    queue_tx(8'hAB);
    i_cs_n = 1'b0;
    tick(6);
    queue_tx(8'hCD);
    tick(2);
    xfer(8'h12, 8, m1);
    xfer(8'h34, 8, m2);
    tick(HP);
    i_cs_n = 1'b1;
    tick(8);
    check("b2b_rx_count", 32'(rx_log.size()), 2);
    if (rx_log.size() == 2) begin
      check("b2b_rx0", 32'(rx_log[0]), 32'h12);
      check("b2b_rx1", 32'(rx_log[1]), 32'h34);
    end
    check("b2b_cipo0", 32'(m1), 32'hAB);
    check("b2b_cipo1", 32'(m2), 32'hCD);

    // Partial byte: CS_N raised after 4 bits; byte queued mid-window survives.
    apply_mode(2'd0);
    a0 = abort_cnt;
    queue_tx(8'h5A);
    rx_log.delete();
    i_cs_n = 1'b0;
    tick(6);
    queue_tx(8'h77);
    tick(2);
    xfer(8'hF0, 4, mi);
    tick(HP);
    i_cs_n = 1'b1;
    tick(8);
    check("abort_no_rx", 32'(rx_log.size()), 0);
    check("abort_partial_cipo", 32'(mi[7:4]), 32'h5);
`ifdef SPI_PERIPHERAL_ERR_EN
    check("abort_pulse", 32'(abort_cnt - a0), 1);
`endif
    run_window(8'h81, 1'b0, 8'h00, mi);
    check_rx1("after_abort", 8'h81);
    check("after_abort_cipo", 32'(mi), 32'h77);

    // Config mid-transfer is ignored; the peripheral keeps sampling in mode 0.
    queue_tx(8'h96);
    rx_log.delete();
    i_cs_n = 1'b0;
    tick(5);
    i_config = 3'b101;
    tick(1);
    i_config = 3'b000;
    tick(2);
    xfer(8'hC3, 8, mi);
    tick(HP);
    i_cs_n = 1'b1;
    tick(8);
    check_rx1("cfg_ignored", 8'hC3);
    check("cfg_ignored_cipo", 32'(mi), 32'h96);
    apply_mode(2'd2);
    run_window(8'h6B, 1'b1, 8'h2D, mi);
    check_rx1("cfg_mode2", 8'h6B);
    check("cfg_mode2_cipo", 32'(mi), 32'h2D);

    // Reset mid-byte: outputs return to reset values and the window does not resume.
    queue_tx(8'h44);
    rx_log.delete();
    i_cs_n = 1'b0;
    tick(8);
    xfer(8'hFF, 4, mi);
    i_rst_n = 1'b0;
    tick(2);
    reset_checks("midrst");
    i_rst_n = 1'b1;
    tick(2);
    reset_checks("midrst_rel");
    xfer(8'hFF, 4, mi);
    tick(HP);
    check("midrst_busy_low", 32'(o_busy), 0);
    i_cs_n = 1'b1;
    tick(8);
    check("midrst_no_rx", 32'(rx_log.size()), 0);
    cpol = 1'b0;
    cpha = 1'b0;
    i_sclk = 1'b0;
    tick(6);
    run_window(8'h99, 1'b1, 8'h18, mi);
    check_rx1("midrst_default_mode", 8'h99);
    check("midrst_default_cipo", 32'(mi), 32'h18);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI target (peripheral) side of the link driven by the team's SPI controller; runs on the system clock and oversamples SCLK, CS_N and COPI.
- Receives bytes MSB-first into o_rx and shifts a byte supplied over a ready/valid port out on CIPO.
- Supports SPI modes 0-3, selected at runtime through a config port; used as loopback or target endpoint in SoC integration and benches.

Parameters:
- DEFAULT_MODE, 2'd0, SPI mode after reset {CPOL,CPHA}
- SYNC_STAGES, 2, flip-flop synchronizer depth on i_sclk, i_cs_n, i_copi (minimum 2)
- UNDERRUN_BYTE, 8'hFF, byte shifted out when no TX data is held at a byte start

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_config  in  3  {mode[1:0], load}; load=1 latches mode
- i_tx  in  8  byte to send to controller
- i_tx_valid  in  1  i_tx valid
- o_tx_ready  out  1  holding register empty, accepts i_tx
- o_rx  out  8  last complete received byte
- o_rx_valid  out  1  one-cycle pulse, o_rx updated
- o_busy  out  1  CS asserted (synchronized)
- i_sclk  in  1  SPI clock from controller (asynchronous)
- i_cs_n  in  1  chip select, active low (asynchronous)
- i_copi  in  1  controller-out data (asynchronous)
- o_cipo  out  1  peripheral-out data
- o_cipo_oe  out  1  CIPO output enable (high while selected)

Behaviour:
- Reset values: o_tx_ready=1, o_rx=0, o_rx_valid=0, o_busy=0, o_cipo=0, o_cipo_oe=0, mode=DEFAULT_MODE, holding register empty, bit counter=0.
- Synchronize SCLK/CS_N/COPI through SYNC_STAGES FFs; one extra register gives the edge detect. Pin-to-internal-event latency is SYNC_STAGES+1 cycles.
- Timing constraint: each SCLK half-period is at least 4 i_clk cycles.
- Config: mode is latched on i_config[0]=1 only while the synchronized CS_N is high. Config during a transfer is ignored.
- Edges:
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1.
  - Shift edge = the other edge.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
- FSM:
  - IDLE -> LOAD on CS_N falling.
  - LOAD: one cycle; moves holding register (or UNDERRUN_BYTE if empty) into the TX shift register; o_tx_ready re-asserts. CPHA=0 drives MSB on o_cipo now. Then -> SHIFT.
  - SHIFT: on each sample edge, shift i_copi into the RX register and increment the bit counter 0..7.
  - Shift edges: CPHA=0 -> present next bit; CPHA=1 -> present current bit (first shift edge drives MSB).
  - After the 8th sample: o_rx updates, o_rx_valid pulses 1 cycle, bit counter wraps to 0.
  - Next byte load: CPHA=0 on the following shift edge, which drives the new MSB; CPHA=1 immediately.
  - CS_N rising -> IDLE from any state.
- TX handshake:
  - Transfer when i_tx_valid && o_tx_ready; o_tx_ready deasserts the next cycle.
  - A load and a new accept in the same cycle are both honoured: the old byte goes to the shift register, the new byte to the holding register.
- o_cipo_oe = o_busy. o_cipo=0 while not busy.
- CS_N rising mid-byte:
  - Partial byte discarded, no o_rx_valid, bit counter cleared.
  - Holding register untouched; byte already loaded into the shift register is lost.
- i_rst_n low mid-transfer forces reset values immediately. Transfer resumes only after a new CS_N falling edge.
- Two back-to-back bytes in one CS window are supported without gaps.

Optional Feature:
- Macro SPI_PERIPHERAL_ERR_EN.
- Defined: adds outputs o_underrun (1-cycle pulse when LOAD uses UNDERRUN_BYTE) and o_abort (1-cycle pulse when CS_N deasserts with bit counter != 0).
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Mode 0, half-period 4 cycles, peripheral preloaded with 0x3C, controller sends 0xA5 -> o_rx=0xA5 with one o_rx_valid pulse; controller receives 0x3C.
- Modes 1/2/3, 255 random byte pairs each, one byte per CS window -> every o_rx matches sent byte; controller receives every queued byte.
- Mode 3, one CS window, bytes 0x12,0x34 sent with 0xAB,0xCD queued -> two o_rx_valid pulses (0x12, 0x34); controller gets 0xAB, 0xCD.
- No TX queued, controller sends 0x55 -> o_rx=0x55; controller receives 0xFF; o_underrun pulses once (with macro).
- CS_N raised after 4 bits, then full byte 0x81 -> no o_rx_valid for partial, then o_rx=0x81; o_abort pulses once (with macro).
- Config mode=2 applied mid-transfer then after CS_N high; i_rst_n pulsed mid-byte -> first config ignored, second takes effect; after reset all outputs at reset values, o_tx_ready=1.
